// File: rtl/prime_sweep_pkg.sv
// prime_sweep_pkg: shared types and constants for the prime sweep controller.
package prime_sweep_pkg;
    localparam int NUM_W = 5;
    localparam int N_PRIMES = 6;
    localparam logic [NUM_W-1:0] PRIME_MIN = 5'd2;
    localparam logic [NUM_W-1:0] PRIME_MAX = 5'd13;
    // Entry i of the sequence lives at bits [i*NUM_W +: NUM_W], ascending order.
    localparam logic [N_PRIMES*NUM_W-1:0] PRIME_TABLE = {5'd13, 5'd11, 5'd7, 5'd5, 5'd3, 5'd2};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_HOLD,
        S_DONE
    } state_t;
endpackage

// File: rtl/prime_step.sv
// prime_step: combinational neighbour lookup within the prime sequence.
module prime_step
    import prime_sweep_pkg::*;
(
    input  logic [NUM_W-1:0] number,
    input  logic             dir,
    input  logic             wrap_en,
    output logic [NUM_W-1:0] next_number,
    output logic             at_end
);
    logic [NUM_W-1:0] up;
    logic [NUM_W-1:0] dn;

    // Defaults supply the wrap targets: only 13 has no successor and only 2 no predecessor.
    always_comb begin
        up = PRIME_MIN;
        dn = PRIME_MAX;
        for (int i = 0; i < N_PRIMES - 1; i++) begin
            if (number == PRIME_TABLE[i*NUM_W +: NUM_W]) up = PRIME_TABLE[(i+1)*NUM_W +: NUM_W];
            if (number == PRIME_TABLE[(i+1)*NUM_W +: NUM_W]) dn = PRIME_TABLE[i*NUM_W +: NUM_W];
        end
    end

    assign at_end = dir ? (number == PRIME_MIN) : (number == PRIME_MAX);
    assign next_number = (at_end && !wrap_en) ? number : (dir ? dn : up);
endmodule

// File: rtl/prime_sweep_ctrl.sv
// prime_sweep_ctrl: command-driven sequencer stepping through the primes 2..13.
// Define PRIME_SWEEP_WRAP_EN to wrap at the sequence ends instead of stopping.
module prime_sweep_ctrl
    import prime_sweep_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic             cmd_load,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] number,
    output logic             busy,
    output logic             done,
    output logic             at_limit
);
`ifdef PRIME_SWEEP_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    state_t state;
    state_t state_n;
    logic [CNT_W-1:0] remaining;
    logic dir;
    logic load;
    logic [NUM_W-1:0] next_number;
    logic at_end;
    logic stop;

    prime_step u_step (
        .number(number),
        .dir(dir),
        .wrap_en(WRAP_EN),
        .next_number(next_number),
        .at_end(at_end)
    );

    assign stop = at_end && !WRAP_EN;
    assign cmd_ready = (state == S_IDLE);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (cmd_valid) state_n = S_LOAD;
            S_LOAD: state_n = (remaining == '0) ? S_DONE : S_STEP;
            S_STEP: state_n = stop ? S_DONE : S_HOLD;
            S_HOLD: if (out_ready) state_n = (remaining == '0) ? S_DONE : S_STEP;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            number <= PRIME_MIN;
            out_valid <= 1'b0;
            done <= 1'b0;
            at_limit <= 1'b0;
            remaining <= '0;
            dir <= 1'b0;
            load <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (cmd_valid) begin
                    dir <= cmd_dir;
                    load <= cmd_load;
                    remaining <= cmd_count;
                end
                S_LOAD: begin
                    if (load) number <= dir ? PRIME_MAX : PRIME_MIN;
                    at_limit <= 1'b0;
                end
                // A blocked limit step ends the command without emitting a beat.
                S_STEP: if (stop) begin
                    at_limit <= 1'b1;
                    remaining <= '0;
                end else begin
                    number <= next_number;
                    out_valid <= 1'b1;
                    remaining <= remaining - 1'b1;
                end
                S_HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// tb_prime_sweep_ctrl: directed stimulus with a queue scoreboard for beats and done pulses.
module tb_prime_sweep_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic cmd_dir = 1'b0;
    logic cmd_load = 1'b0;
    logic [3:0] cmd_count = 4'd0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [4:0] number;
    logic busy;
    logic done;
    logic at_limit;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_beats[$];
    logic [5:0] exp_done[$];

    prime_sweep_ctrl #(.CNT_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_load(cmd_load),
        .cmd_count(cmd_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .number(number),
        .busy(busy),
        .done(done),
        .at_limit(at_limit)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted beat and every done pulse against the queues.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_beats.size() == 0) check("unexpected_beat", {27'd0, number}, 32'd99);
            else check("beat", {27'd0, number}, {27'd0, exp_beats.pop_front()});
        end
        if (reset && done) begin
            if (exp_done.size() == 0) check("unexpected_done", {26'd0, at_limit, number}, 32'd99);
            else check("done_limit_number", {26'd0, at_limit, number}, {26'd0, exp_done.pop_front()});
        end
    end

    task automatic issue(input logic d, input logic l, input logic [3:0] c);
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_load = l;
        cmd_count = c;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_number", {27'd0, number}, 2);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_at_limit", {31'd0, at_limit}, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Ascending from reload, consumer always ready: beats 3,5,7.
        out_ready = 1'b1;
        exp_beats.push_back(5'd3);
        exp_beats.push_back(5'd5);
        exp_beats.push_back(5'd7);
        exp_done.push_back({1'b0, 5'd7});
        issue(1'b0, 1'b1, 4'd3);
        @(negedge clock);
        check("a_ready_drop", {31'd0, cmd_ready}, 0);
        check("a_load_no_valid", {31'd0, out_valid}, 0);
        @(negedge clock);
        check("a_step_no_valid", {31'd0, out_valid}, 0);
        @(negedge clock);
        check("a_first_valid", {31'd0, out_valid}, 1);
        wait_done("a");
        check("a_at_limit", {31'd0, at_limit}, 0);

        // Descending reload with a stalled consumer.
        out_ready = 1'b0;
        exp_beats.push_back(5'd11);
        exp_beats.push_back(5'd7);
        exp_done.push_back({1'b0, 5'd7});
        issue(1'b1, 1'b1, 4'd2);
        wait_valid("b");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("b_hold_number", {27'd0, number}, 11);
            check("b_hold_valid", {31'd0, out_valid}, 1);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_done("b");

        exp_beats.push_back(5'd11);
        exp_done.push_back({1'b0, 5'd11});
        issue(1'b0, 1'b0, 4'd1);
        wait_done("c1");

        // Ascend from 11 through the top of the sequence.
`ifdef PRIME_SWEEP_WRAP_EN
        exp_beats.push_back(5'd13);
        exp_beats.push_back(5'd2);
        exp_beats.push_back(5'd3);
        exp_beats.push_back(5'd5);
        exp_done.push_back({1'b0, 5'd5});
        issue(1'b0, 1'b0, 4'd4);
        wait_done("c2");
        check("c2_number", {27'd0, number}, 5);
        check("c2_at_limit", {31'd0, at_limit}, 0);
`else
        exp_beats.push_back(5'd13);
        exp_done.push_back({1'b1, 5'd13});
        issue(1'b0, 1'b0, 4'd4);
        wait_done("c2");
        check("c2_number", {27'd0, number}, 13);
        check("c2_at_limit", {31'd0, at_limit}, 1);
`endif

        // Zero-step command; a second command offered while busy must be ignored.
`ifdef PRIME_SWEEP_WRAP_EN
        exp_done.push_back({1'b0, 5'd5});
`else
        exp_done.push_back({1'b0, 5'd13});
`endif
        issue(1'b0, 1'b0, 4'd0);
        cmd_valid = 1'b1;
        cmd_load = 1'b1;
        cmd_count = 4'd5;
        @(negedge clock);
        check("z_busy", {31'd0, busy}, 1);
        check("z_ready_busy", {31'd0, cmd_ready}, 0);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        @(negedge clock);
        check("z_done_early", {31'd0, done}, 0);
        @(negedge clock);
        check("z_done_pulse", {31'd0, done}, 1);
        @(negedge clock);
        check("z_done_single", {31'd0, done}, 0);
        check("z_idle_ready", {31'd0, cmd_ready}, 1);
        repeat (3) @(negedge clock);
        check("z_ignored_busy", {31'd0, busy}, 0);
        check("z_ignored_valid", {31'd0, out_valid}, 0);

        // Reset while a beat is held.
        out_ready = 1'b0;
        issue(1'b1, 1'b1, 4'd3);
        wait_valid("r");
        #2 reset = 1'b0;
        #1;
        check("r_number", {27'd0, number}, 2);
        check("r_out_valid", {31'd0, out_valid}, 0);
        check("r_busy", {31'd0, busy}, 0);
        check("r_cmd_ready", {31'd0, cmd_ready}, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("r_stays_idle", {31'd0, busy}, 0);

        check("beats_left", exp_beats.size(), 0);
        check("dones_left", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
